// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch and IF/ID pipeline register of the DLX core.
//
// Holds the fetch PC, which addresses a combinational instruction memory.
// Each cycle the returned word and PC+4 are latched into the IF/ID register.
// Branch/jump redirects squash IF/ID, and the hazard unit can stall fetch.
// Fetching a TRAP instruction halts fetch until a redirect arrives.
//
// Ports:
//   clk              clock, rising edge
//   reset            asynchronous, active-high
//   stall            hold PC, IF/ID, state and fetch_count this cycle
//   redirect_valid   taken branch/jump: load redirect_target, squash IF/ID
//   redirect_target  new PC (not alignment-checked)
//   imem_dout        instruction at pc_out, same cycle
//   pc_out           current fetch PC
//   instr_fd         IF/ID instruction
//   pc_plus_four_fd  IF/ID PC+4 of instr_fd
//   valid_fd         instr_fd is a real fetched instruction (0 = bubble)
//   halted           fetch stopped after TRAP
//   fetch_count      number of valid instructions latched into IF/ID
//
// Bit 0 is the MSB of every 32-bit bus; the opcode is bits [0:5].
module fetch_stage #(
  parameter logic [0:31] RESET_PC = 32'h0000_0000,
  parameter logic [0:31] NOP_WORD = 32'h0000_0015,
  parameter logic [0:5]  TRAP_OP  = 6'h11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [0:31] redirect_target,
  input  logic [0:31] imem_dout,
  output logic [0:31] pc_out,
  output logic [0:31] instr_fd,
  output logic [0:31] pc_plus_four_fd,
  output logic        valid_fd,
  output logic        halted,
  output logic [0:31] fetch_count
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

  state_t      state_reg;
  logic [0:31] pc_reg;
  logic [0:31] instr_fd_reg;
  logic [0:31] pc_plus_four_fd_reg;
  logic        valid_fd_reg;
  logic [0:31] fetch_count_reg;

  // Wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
  logic [0:31] pc_next_seq;
  logic        is_trap;

  assign pc_next_seq = pc_reg + 32'd4;
  assign is_trap     = (imem_dout[0:5] == TRAP_OP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg           <= ST_RUN;
      pc_reg              <= RESET_PC;
      instr_fd_reg        <= NOP_WORD;
      pc_plus_four_fd_reg <= '0;
      valid_fd_reg        <= 1'b0;
      fetch_count_reg     <= '0;
    end else if (redirect_valid) begin
      // Redirect wins over stall and also rescues a wrong-path TRAP halt.
      state_reg           <= ST_RUN;
      pc_reg              <= redirect_target;
      instr_fd_reg        <= NOP_WORD;
      pc_plus_four_fd_reg <= '0;
      valid_fd_reg        <= 1'b0;
    end else if (stall) begin
      // Everything holds, including a TRAP sitting in IF/ID.
    end else if (state_reg == ST_RUN) begin
      instr_fd_reg        <= imem_dout;
      pc_plus_four_fd_reg <= pc_next_seq;
      valid_fd_reg        <= 1'b1;
      fetch_count_reg     <= fetch_count_reg + 32'd1;
      if (is_trap) begin
        // TRAP itself goes down the pipe, but the PC stops on it.
        state_reg <= ST_HALTED;
      end else begin
        pc_reg <= pc_next_seq;
      end
    end else begin
      // Halted: keep feeding bubbles into decode.
      instr_fd_reg        <= NOP_WORD;
      pc_plus_four_fd_reg <= '0;
      valid_fd_reg        <= 1'b0;
    end
  end

  assign pc_out          = pc_reg;
  assign instr_fd        = instr_fd_reg;
  assign pc_plus_four_fd = pc_plus_four_fd_reg;
  assign valid_fd        = valid_fd_reg;
  assign halted          = (state_reg == ST_HALTED);
  assign fetch_count     = fetch_count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage -- directed-vector bench for fetch_stage with a small
// combinational instruction-memory model (64 words, word index = pc[7:2]).
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [0:31] redirect_target;
  logic [0:31] imem_dout;
  logic [0:31] pc_out;
  logic [0:31] instr_fd;
  logic [0:31] pc_plus_four_fd;
  logic        valid_fd;
  logic        halted;
  logic [0:31] fetch_count;

  int checks;
  int errors;

  localparam logic [31:0] NOP      = 32'h0000_0015;
  localparam logic [31:0] TRAP_INS = 32'h4400_0000;

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_dout       (imem_dout),
    .pc_out          (pc_out),
    .instr_fd        (instr_fd),
    .pc_plus_four_fd (pc_plus_four_fd),
    .valid_fd        (valid_fd),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: word i = 32'h1000_0000 | i (opcode 0x04), except a TRAP at 0x10.
  function automatic logic [31:0] word_at(input int idx);
    if (idx == 4) return TRAP_INS;
    return 32'h1000_0000 | 32'(idx);
  endfunction

  // pc bits [24:29] are the byte-address bits 7..2 in MSB-0 numbering.
  always_comb imem_dout = word_at(int'(pc_out[24:29]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    else
      $display("ok   %s = %08h", tag, got);
    if (got !== exp) errors++;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;

    // T1: reset values while reset is held
    #2;
    chk("rst_pc",    pc_out,          32'h0);
    chk("rst_instr", instr_fd,        NOP);
    chk("rst_ppf",   pc_plus_four_fd, 32'h0);
    chk("rst_valid", 32'(valid_fd),   32'h0);
    chk("rst_halt",  32'(halted),     32'h0);
    chk("rst_cnt",   fetch_count,     32'h0);

    @(negedge clk);
    reset = 1'b0;
    step;
    chk("t1_e1_instr", instr_fd,      word_at(0));
    chk("t1_e1_valid", 32'(valid_fd), 32'h1);
    step;
    chk("t1_e2_pc",    pc_out,        32'h8);
    chk("t1_e2_cnt",   fetch_count,   32'h2);

    // T2: stall two edges at pc 8
    stall = 1'b1;
    step;
    step;
    chk("t2_stall_pc",    pc_out,      32'h8);
    chk("t2_stall_instr", instr_fd,    word_at(1));
    chk("t2_stall_cnt",   fetch_count, 32'h2);
    stall = 1'b0;
    step;
    chk("t2_rel_instr", instr_fd,        word_at(2));
    chk("t2_rel_ppf",   pc_plus_four_fd, 32'hC);
    chk("t2_rel_pc",    pc_out,          32'hC);
    chk("t2_rel_cnt",   fetch_count,     32'h3);

    // T3: redirect together with stall; redirect wins
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    stall           = 1'b1;
    step;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    chk("t3_pc",    pc_out,          32'h40);
    chk("t3_instr", instr_fd,        NOP);
    chk("t3_valid", 32'(valid_fd),   32'h0);
    chk("t3_ppf",   pc_plus_four_fd, 32'h0);
    chk("t3_cnt",   fetch_count,     32'h3);
    step;
    chk("t3_n_instr", instr_fd,    word_at(16));
    chk("t3_n_pc",    pc_out,      32'h44);
    chk("t3_n_cnt",   fetch_count, 32'h4);

    // T4: TRAP at 0x10 halts fetch
    redirect_valid  = 1'b1;
    redirect_target = 32'h10;
    step;
    redirect_valid = 1'b0;
    step;
    chk("t4_instr", instr_fd,        TRAP_INS);
    chk("t4_valid", 32'(valid_fd),   32'h1);
    chk("t4_halt",  32'(halted),     32'h1);
    chk("t4_pc",    pc_out,          32'h10);
    chk("t4_ppf",   pc_plus_four_fd, 32'h14);
    chk("t4_cnt",   fetch_count,     32'h5);
    step;
    chk("t4_b_instr", instr_fd,      NOP);
    chk("t4_b_valid", 32'(valid_fd), 32'h0);
    chk("t4_b_pc",    pc_out,        32'h10);
    chk("t4_b_cnt",   fetch_count,   32'h5);

    // T5: redirect out of HALTED
    redirect_valid  = 1'b1;
    redirect_target = 32'h20;
    step;
    redirect_valid = 1'b0;
    chk("t5_halt", 32'(halted), 32'h0);
    chk("t5_pc",   pc_out,      32'h20);
    step;
    chk("t5_instr", instr_fd,      word_at(8));
    chk("t5_valid", 32'(valid_fd), 32'h1);
    chk("t5_cnt",   fetch_count,   32'h6);

    // PC wrap at 32'hFFFF_FFFC
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step;
    redirect_valid = 1'b0;
    step;
    chk("wrap_instr", instr_fd,        word_at(63));
    chk("wrap_ppf",   pc_plus_four_fd, 32'h0);
    chk("wrap_pc",    pc_out,          32'h0);
    chk("wrap_cnt",   fetch_count,     32'h7);

    // Unaligned redirect target passes through unchanged
    redirect_valid  = 1'b1;
    redirect_target = 32'h42;
    step;
    redirect_valid = 1'b0;
    chk("unal_pc", pc_out, 32'h42);
    step;
    chk("unal_ppf", pc_plus_four_fd, 32'h46);
    chk("unal_n_pc", pc_out,         32'h46);

    // T6: asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    chk("t6_pc",    pc_out,        32'h0);
    chk("t6_instr", instr_fd,      NOP);
    chk("t6_valid", 32'(valid_fd), 32'h0);
    chk("t6_cnt",   fetch_count,   32'h0);
    chk("t6_halt",  32'(halted),   32'h0);
    @(negedge clk);
    reset = 1'b0;
    step;
    chk("t6_r_instr", instr_fd,    word_at(0));
    chk("t6_r_pc",    pc_out,      32'h4);
    chk("t6_r_cnt",   fetch_count, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
